// File: rtl/nand_target_responder.sv
// NAND flash target (device side): oversamples the CLE/ALE/WE#/RE# bus, decodes
// latch cycles and serves one page buffer with ONFI-style busy, status and data-out.
module nand_target_responder #(
    parameter int unsigned PAGE_BYTES = 64,
    parameter int unsigned T_READ     = 40,
    parameter int unsigned T_PROG     = 200,
    parameter int unsigned T_ERASE    = 400,
    parameter int unsigned T_RST      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_n,
    input  logic        cle,
    input  logic        ale,
    input  logic        we_n,
    input  logic        re_n,
    input  logic [7:0]  dq_in,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    output logic        rb_n,
    input  logic        fail_inject,
    output logic [23:0] row_addr,
    output logic        cmd_error
);

    localparam int unsigned COL_W = $clog2(PAGE_BYTES);
    localparam int unsigned CNT_W = $clog2(T_READ + T_PROG + T_ERASE + T_RST + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StDin, StBusy, StDout, StStat} state_e;
    typedef enum logic [1:0] {OpRead, OpProg, OpErase, OpReset} op_e;

    // {ce_n, cle, ale, we_n, re_n}
    logic [4:0]       ctl_s1_q, ctl_s2_q;
    logic [7:0]       dq_s1_q, dq_s2_q;
    logic             we_prev_q, re_prev_q;
    logic             ce_s, cle_s, ale_s, we_s, re_s;
    logic [7:0]       dq_s;
    logic             we_evt, re_evt, re_fall, re_rise;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [2:0]       addr_cnt_q, addr_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       col_lo_q, col_lo_d, r1_q, r1_d, r2_q, r2_d;
    logic [23:0]      row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rb_q, rb_d, fail_q, fail_d, err_q, err_d;
    logic [7:0]       status_q, status_d, dq_out_q, dq_out_d;
    logic [COL_W:0]   ers_q, ers_d;

    logic [7:0]       mem_q [PAGE_BYTES];
    logic             mem_we;
    logic [COL_W-1:0] mem_addr;
    logic [7:0]       mem_wdata;

    logic             bad, host_ok, row_ok;
    logic [2:0]       row_idx;

    assign {ce_s, cle_s, ale_s, we_s, re_s} = ctl_s2_q;
    assign dq_s    = dq_s2_q;
    assign re_fall = !re_s && re_prev_q;
    assign re_rise = re_s && !re_prev_q;
    assign we_evt  = !ce_s && we_s && !we_prev_q;
    assign re_evt  = !ce_s && (re_fall || re_rise);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_s1_q   <= 5'b10011;
            ctl_s2_q   <= 5'b10011;
            dq_s1_q    <= 8'h00;
            dq_s2_q    <= 8'h00;
            we_prev_q  <= 1'b1;
            re_prev_q  <= 1'b1;
            state_q    <= StIdle;
            op_q       <= OpReset;
            addr_cnt_q <= 3'd0;
            col_q      <= '0;
            col_lo_q   <= 8'h00;
            r1_q       <= 8'h00;
            r2_q       <= 8'h00;
            row_q      <= 24'h0;
            cnt_q      <= '0;
            rb_q       <= 1'b1;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            status_q   <= 8'hC0;
            dq_out_q   <= 8'h00;
            ers_q      <= {1'b1, {COL_W{1'b0}}};
        end else begin
            ctl_s1_q   <= {ce_n, cle, ale, we_n, re_n};
            ctl_s2_q   <= ctl_s1_q;
            dq_s1_q    <= dq_in;
            dq_s2_q    <= dq_s1_q;
            we_prev_q  <= we_s;
            re_prev_q  <= re_s;
            state_q    <= state_d;
            op_q       <= op_d;
            addr_cnt_q <= addr_cnt_d;
            col_q      <= col_d;
            col_lo_q   <= col_lo_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            rb_q       <= rb_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            status_q   <= status_d;
            dq_out_q   <= dq_out_d;
            ers_q      <= ers_d;
        end
    end

    // Page buffer survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_cnt_d = addr_cnt_q;
        col_d      = col_q;
        col_lo_d   = col_lo_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        rb_d       = rb_q;
        fail_d     = fail_q;
        err_d      = 1'b0;
        status_d   = status_q;
        dq_out_d   = dq_out_q;
        ers_d      = ers_q;
        mem_we     = 1'b0;
        mem_addr   = col_q;
        mem_wdata  = dq_s;
        bad        = 1'b0;
        host_ok    = state_q inside {StIdle, StDout, StStat};
        row_ok     = (op_q == OpErase) || (addr_cnt_q >= 3'd2);
        row_idx    = (op_q == OpErase) ? addr_cnt_q : addr_cnt_q - 3'd2;

        if (state_q == StBusy) begin
            // Erase clears the buffer one byte per clk while busy.
            if (op_q == OpErase && !ers_q[COL_W]) begin
                mem_we    = 1'b1;
                mem_addr  = ers_q[COL_W-1:0];
                mem_wdata = 8'hFF;
                ers_d     = ers_q + (COL_W+1)'(1);
            end
            if (cnt_q <= CNT_W'(1)) begin
                cnt_d    = '0;
                rb_d     = 1'b1;
                status_d = {2'b11, 5'b00000, fail_q};
                state_d  = (op_q == OpRead) ? StDout : StIdle;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (we_evt) begin
            if (cle_s && ale_s) begin
                err_d = 1'b1;
            end else if (cle_s) begin
                if (dq_s == 8'hFF) begin
                    state_d = StBusy;
                    op_d    = OpReset;
                    cnt_d   = CNT_W'(T_RST);
                    rb_d    = 1'b0;
                    fail_d  = 1'b0;
                end else if (state_q != StBusy) begin
                    case (dq_s)
                        8'h70: begin
                            if (host_ok) begin
                                state_d  = StStat;
                                dq_out_d = status_q;
                            end else bad = 1'b1;
                        end
                        8'h00, 8'h80, 8'h60: begin
                            if (host_ok) begin
                                state_d    = StAddr;
                                addr_cnt_d = 3'd0;
                                op_d = (dq_s == 8'h00) ? OpRead :
                                       (dq_s == 8'h80) ? OpProg : OpErase;
                            end else bad = 1'b1;
                        end
                        8'h30: begin
                            if (state_q == StAddr && op_q == OpRead && addr_cnt_q == 3'd5) begin
                                state_d = StBusy;
                                cnt_d   = CNT_W'(T_READ);
                                rb_d    = 1'b0;
                                fail_d  = 1'b0;
                            end else bad = 1'b1;
                        end
                        8'h10: begin
                            if (state_q == StDin) begin
                                state_d = StBusy;
                                cnt_d   = CNT_W'(T_PROG);
                                rb_d    = 1'b0;
                                fail_d  = fail_inject;
                            end else bad = 1'b1;
                        end
                        8'hD0: begin
                            if (state_q == StAddr && op_q == OpErase && addr_cnt_q == 3'd3) begin
                                state_d = StBusy;
                                cnt_d   = CNT_W'(T_ERASE);
                                rb_d    = 1'b0;
                                fail_d  = fail_inject;
                                ers_d   = '0;
                            end else bad = 1'b1;
                        end
                        default: bad = 1'b1;
                    endcase
                end
            end else if (ale_s) begin
                if (state_q == StAddr) begin
                    addr_cnt_d = (addr_cnt_q == 3'd7) ? addr_cnt_q : addr_cnt_q + 3'd1;
                    if (op_q != OpErase && addr_cnt_q == 3'd0) col_lo_d = dq_s;
                    if (op_q != OpErase && addr_cnt_q == 3'd1) col_d = COL_W'({dq_s, col_lo_q});
                    if (row_ok) begin
                        case (row_idx)
                            3'd0:    r1_d = dq_s;
                            3'd1:    r2_d = dq_s;
                            3'd2:    row_d = {dq_s, r2_q, r1_q};
                            default: ;
                        endcase
                    end
                    if (op_q == OpProg && addr_cnt_q == 3'd4) state_d = StDin;
                end else if (state_q != StBusy) begin
                    bad = 1'b1;
                end
            end else begin
                if (state_q == StDin) begin
                    mem_we = 1'b1;
                    col_d  = col_q + COL_W'(1);
                end else if (state_q != StBusy) begin
                    bad = 1'b1;
                end
            end
            // A coincident re_n edge loses to we_n and is flagged.
            if (re_evt) err_d = 1'b1;
        end else if (re_evt) begin
            if (state_q == StDout) begin
                if (re_fall) dq_out_d = mem_q[col_q];
                if (re_rise) col_d = col_q + COL_W'(1);
            end else if (state_q == StStat && re_fall) begin
                dq_out_d = status_q;
            end
        end

        if (bad) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
    end

    assign dq_out    = dq_out_q;
    assign dq_oe     = (state_q == StDout || state_q == StStat) && !re_s && !ce_s;
    assign rb_n      = rb_q;
    assign row_addr  = row_q;
    assign cmd_error = err_q;

endmodule

// File: tb/tb_nand_target_responder.sv
// Directed bench for nand_target_responder: a page/status/timing model checked every cycle,
// plus hand-computed literals for the key results.
module tb_nand_target_responder;

    localparam int PB = 64;
    localparam int TR = 40;
    localparam int TP = 200;
    localparam int TE = 400;
    localparam int TS = 20;

    logic        clk = 1'b0;
    logic        rst, ce_n, cle, ale, we_n, re_n, fail_inject;
    logic [7:0]  dq_in, dq_out;
    logic        dq_oe, rb_n, cmd_error;
    logic [23:0] row_addr;

    always #5 clk = ~clk;

    nand_target_responder #(
        .PAGE_BYTES (PB),
        .T_READ     (TR),
        .T_PROG     (TP),
        .T_ERASE    (TE),
        .T_RST      (TS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_n        (ce_n),
        .cle         (cle),
        .ale         (ale),
        .we_n        (we_n),
        .re_n        (re_n),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .rb_n        (rb_n),
        .fail_inject (fail_inject),
        .row_addr    (row_addr),
        .cmd_error   (cmd_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: page contents, read column, status, and the cycle windows of bus-visible events.
    logic [7:0]  mbuf [PB];
    int          mcol;
    logic [7:0]  mstatus = 8'hC0;
    bit          oe_mode = 1'b0;
    int          busy_start = 0, busy_end = 0;
    int          err_at = -1;
    int          row_at = 32'h7fffffff;
    logic [23:0] row_new = 24'h0, exp_row = 24'h0;
    int          pend_busy = 0;
    bit          pend_err = 1'b0;
    bit          pend_row_v = 1'b0;
    logic [23:0] pend_row = 24'h0;
    int          wr_cyc = 0, rise_cyc = 0, low_run = 0, last_low_len = 0, err_seen = 0;
    bit          chk_en = 1'b0;
    logic        re_last = 1'b1, rb_prev = 1'b1;
    int          re_age = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit exp_low;
        if (chk_en) begin
            if (cyc >= row_at) exp_row = row_new;
            exp_low = (cyc >= busy_start) && (cyc < busy_end);
            check("rb_n", {31'b0, rb_n}, {31'b0, !exp_low});
            check("cmd_error", {31'b0, cmd_error}, {31'b0, cyc == err_at});
            check("row_addr", {8'b0, row_addr}, {8'b0, exp_row});
            if (re_n !== re_last) begin
                re_age  = 0;
                re_last = re_n;
            end else begin
                re_age++;
            end
            if (re_age >= 3) check("dq_oe", {31'b0, dq_oe}, {31'b0, !re_n && oe_mode});
            if (rb_n && !rb_prev) rise_cyc = cyc;
            if (!rb_n) low_run++;
            else if (low_run > 0) begin
                last_low_len = low_run;
                low_run      = 0;
            end
            rb_prev = rb_n;
            if (cmd_error) err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One latch cycle; the edge is acted on 3 clk after we_n rises.
    task automatic latch(input logic c, input logic a, input logic [7:0] d);
        int s;
        ce_n = 1'b0; cle = c; ale = a; dq_in = d; we_n = 1'b0;
        tick(5);
        we_n   = 1'b1;
        wr_cyc = cyc;
        s      = cyc + 3;
        if (pend_busy > 0) begin
            if (s >= busy_start && s < busy_end) busy_end = s + pend_busy;
            else begin
                busy_start = s;
                busy_end   = s + pend_busy;
            end
            pend_busy = 0;
        end
        if (pend_err) begin
            err_at   = s;
            pend_err = 1'b0;
        end
        if (pend_row_v) begin
            row_at     = s;
            row_new    = pend_row;
            pend_row_v = 1'b0;
        end
        tick(5);
        cle = 1'b0; ale = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);  latch(1'b1, 1'b0, d); endtask
    task automatic addr(input logic [7:0] d); latch(1'b0, 1'b1, d); endtask
    task automatic data(input logic [7:0] d); latch(1'b0, 1'b0, d); endtask

    task automatic addr5(input logic [15:0] col, input logic [23:0] row);
        addr(col[7:0]); addr(col[15:8]); addr(row[7:0]); addr(row[15:8]);
        pend_row_v = 1'b1; pend_row = row;
        addr(row[23:16]);
    endtask

    task automatic re_pulse(output logic [7:0] v, output logic oe);
        re_n = 1'b0;
        tick(5);
        v  = dq_out;
        oe = dq_oe;
        re_n = 1'b1;
        tick(5);
    endtask

    task automatic wait_rb();
        int k = 0;
        while (rb_n !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        check("rb_ready", {31'b0, rb_n}, 32'd1);
        tick(2);
    endtask

    logic [7:0] v;
    logic       oe;
    int         es;

    initial begin
        rst = 1'b0; ce_n = 1'b1; cle = 1'b0; ale = 1'b0; we_n = 1'b1; re_n = 1'b1;
        dq_in = 8'h00; fail_inject = 1'b0;
        tick(3);
        check("rst_rb_n", {31'b0, rb_n}, 32'd1);
        check("rst_dq_oe", {31'b0, dq_oe}, 32'd0);
        check("rst_row", {8'b0, row_addr}, 32'd0);
        check("rst_dq_out", {24'b0, dq_out}, 32'd0);
        check("rst_cmd_error", {31'b0, cmd_error}, 32'd0);
        rst = 1'b1;
        tick(3);
        chk_en = 1'b1;

        // Status after reset
        oe_mode = 1'b1;
        cmd(8'h70);
        re_pulse(v, oe);
        check("stat_reset", {24'b0, v}, 32'h0000_00C0);
        check("stat_oe", {31'b0, oe}, 32'd1);

        // Program a full page
        oe_mode = 1'b0;
        cmd(8'h80);
        addr5(16'h0000, 24'h000123);
        mcol = 0;
        for (int i = 0; i < PB; i++) begin
            logic [7:0] b;
            b = 8'(i) ^ 8'h5A;
            data(b);
            mbuf[mcol] = b;
            mcol = (mcol + 1) % PB;
        end
        pend_busy = TP;
        cmd(8'h10);
        wait_rb();
        check("prog_low_len", last_low_len, 32'd200);
        check("prog_rise", rise_cyc - wr_cyc, 32'd203);
        check("prog_row", {8'b0, row_addr}, 32'h0000_0123);
        mstatus = 8'hC0;
        oe_mode = 1'b1;
        cmd(8'h70);
        re_pulse(v, oe);
        check("prog_status", {24'b0, v}, 32'h0000_00C0);

        // Read from column 5 with wrap
        oe_mode = 1'b0;
        cmd(8'h00);
        addr5(16'h0005, 24'h000123);
        mcol = 5;
        oe_mode = 1'b1;
        pend_busy = TR;
        cmd(8'h30);
        wait_rb();
        check("read_rise", rise_cyc - wr_cyc, 32'd43);
        for (int i = 0; i < PB + 1; i++) begin
            re_pulse(v, oe);
            check("rd_data", {24'b0, v}, {24'b0, mbuf[mcol]});
            check("rd_oe", {31'b0, oe}, 32'd1);
            if (i == 0) check("rd_first", {24'b0, v}, 32'h0000_005F);
            if (i == 59) check("rd_wrap", {24'b0, v}, 32'h0000_005A);
            mcol = (mcol + 1) % PB;
        end

        // Erase with injected failure
        oe_mode = 1'b0;
        fail_inject = 1'b1;
        cmd(8'h60);
        addr(8'h0C); addr(8'h0B);
        pend_row_v = 1'b1; pend_row = 24'h0A0B0C;
        addr(8'h0A);
        pend_busy = TE;
        cmd(8'hD0);
        fail_inject = 1'b0;
        for (int i = 0; i < PB; i++) mbuf[i] = 8'hFF;
        mstatus = 8'hC1;
        wait_rb();
        check("erase_rise", rise_cyc - wr_cyc, 32'd403);
        oe_mode = 1'b1;
        cmd(8'h70);
        re_pulse(v, oe);
        check("erase_status", {24'b0, v}, 32'h0000_00C1);
        check("erase_status_m", {24'b0, v}, {24'b0, mstatus});
        oe_mode = 1'b0;
        cmd(8'h00);
        addr5(16'h0000, 24'h0A0B0C);
        mcol = 0;
        oe_mode = 1'b1;
        pend_busy = TR;
        cmd(8'h30);
        mstatus = 8'hC0;
        wait_rb();
        for (int i = 0; i < 4; i++) begin
            re_pulse(v, oe);
            check("erased_byte", {24'b0, v}, 32'h0000_00FF);
            check("erased_model", {24'b0, v}, {24'b0, mbuf[mcol]});
            mcol = (mcol + 1) % PB;
        end

        // Reset command during program busy
        oe_mode = 1'b0;
        cmd(8'h80);
        addr5(16'h0000, 24'h0A0B0C);
        data(8'h11); mbuf[0] = 8'h11;
        data(8'h22); mbuf[1] = 8'h22;
        pend_busy = TP;
        cmd(8'h10);
        tick(50);
        pend_busy = TS;
        cmd(8'hFF);
        wait_rb();
        check("rst_cmd_rise", rise_cyc - wr_cyc, 32'd23);
        mstatus = 8'hC0;
        oe_mode = 1'b1;
        cmd(8'h70);
        re_pulse(v, oe);
        check("rst_cmd_status", {24'b0, v}, 32'h0000_00C0);

        // Short address sequence before 0x30
        oe_mode = 1'b0;
        cmd(8'h00);
        addr(8'h00); addr(8'h00); addr(8'h0C); addr(8'h0B);
        es = err_seen;
        pend_err = 1'b1;
        cmd(8'h30);
        tick(3);
        check("err_pulses", err_seen - es, 32'd1);
        check("err_rb_n", {31'b0, rb_n}, 32'd1);
        re_pulse(v, oe);
        check("err_idle_oe", {31'b0, oe}, 32'd0);

        tick(5);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
